// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: issue, source, operand and stall signals.
// master drives the decode instruction, register-file data and stage result bus;
// slave (the scoreboard) returns stall, resolved operands, forward hits and the stall counter.
interface hazard_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int DEPTH  = 3
);
   logic                    en;
   logic                    issue_valid;
   logic [REG_AW-1:0]       issue_rd;
   logic                    issue_we;
   logic                    issue_is_load;
   logic [REG_AW-1:0]       src1_addr;
   logic [REG_AW-1:0]       src2_addr;
   logic                    src1_used;
   logic                    src2_used;
   logic [DATA_W-1:0]       rf_rd1_data;
   logic [DATA_W-1:0]       rf_rd2_data;
   logic [DEPTH*DATA_W-1:0] stage_data;
   logic                    flush;
   logic                    stall;
   logic [DATA_W-1:0]       op1;
   logic [DATA_W-1:0]       op2;
   logic                    fwd1_hit;
   logic                    fwd2_hit;
   logic [15:0]             stall_cnt;

   modport master (
      output en, issue_valid, issue_rd, issue_we, issue_is_load,
             src1_addr, src2_addr, src1_used, src2_used,
             rf_rd1_data, rf_rd2_data, stage_data, flush,
      input  stall, op1, op2, fwd1_hit, fwd2_hit, stall_cnt
   );

   modport slave (
      input  en, issue_valid, issue_rd, issue_we, issue_is_load,
             src1_addr, src2_addr, src1_used, src2_used,
             rf_rd1_data, rf_rd2_data, stage_data, flush,
      output stall, op1, op2, fwd1_hit, fwd2_hit, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard detection and operand forwarding between decode and execute, one scoreboard entry per stage.
// Latency: stall/op/hit are combinational from state + decode inputs; scoreboard advances 1 cycle per en edge.
// Backpressure: stall holds fetch/decode and injects a bubble; en=0 freezes entries and stall_cnt.
// Ports: clk, rst (async, active-high); sb = decode bundle (issue/src/rf/stage_data/flush in,
//        stall/op1/op2/fwd1_hit/fwd2_hit/stall_cnt out).
module hazard_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int REG_AW   = 4,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 2,
   parameter bit FWD_EN   = 1'b1
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave sb
);
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              is_load;
   } entry_t;

   entry_t            ent [DEPTH];
   logic [DEPTH-1:0]  ready;
   logic [15:0]       stall_cnt;
   logic [REG_AW-1:0] src_addr [2];
   logic              src_used [2];
   logic [DATA_W-1:0] rf_data  [2];
   logic [DATA_W-1:0] op       [2];
   logic              hit      [2];
   logic              hazard   [2];
   logic              stall;
   logic              issue_ok;

   assign src_addr[0] = sb.src1_addr;
   assign src_addr[1] = sb.src2_addr;
   assign src_used[0] = sb.src1_used;
   assign src_used[1] = sb.src2_used;
   assign rf_data[0]  = sb.rf_rd1_data;
   assign rf_data[1]  = sb.rf_rd2_data;

   // Entry 0 (EX) never forwards: there is no EX-to-decode combinational path.
   // Loads only produce data once they reach LOAD_LAT.
   always_comb begin
      ready = '0;
      for (int k = 0; k < DEPTH; k++) begin
         ready[k] = ent[k].valid && ent[k].we && (k >= 1) &&
                    (!ent[k].is_load || (k >= LOAD_LAT));
      end
   end

   // Only the youngest matching writer counts; an older ready copy of the same
   // register is stale and must not be forwarded past a pending younger write.
   always_comb begin
      logic found;
      found = 1'b0;
      for (int s = 0; s < 2; s++) begin
         found     = 1'b0;
         op[s]     = rf_data[s];
         hit[s]    = 1'b0;
         hazard[s] = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            if (src_used[s] && !found && ent[k].valid && ent[k].we &&
                (ent[k].rd == src_addr[s])) begin
               found = 1'b1;
               if (FWD_EN && ready[k]) begin
                  hit[s] = 1'b1;
                  op[s]  = sb.stage_data[k*DATA_W +: DATA_W];
               end else begin
                  hazard[s] = 1'b1;
               end
            end
         end
      end
   end

   // A flushed instruction is dead, so it never stalls.
   assign stall    = sb.issue_valid && (hazard[0] || hazard[1]) && !sb.flush;
   assign issue_ok = sb.issue_valid && !stall && !sb.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent[k] <= '0;
         end
         stall_cnt <= '0;
      end else if (sb.en) begin
         // The oldest entry drops off here; the register file commits it this cycle.
         for (int k = DEPTH - 1; k >= 1; k--) begin
            ent[k] <= ent[k-1];
         end
         if (issue_ok) begin
            ent[0] <= '{valid: 1'b1, rd: sb.issue_rd, we: sb.issue_we, is_load: sb.issue_is_load};
         end else begin
            ent[0] <= '0;
         end
         if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

   assign sb.stall     = stall;
   assign sb.op1       = op[0];
   assign sb.op2       = op[1];
   assign sb.fwd1_hit  = hit[0];
   assign sb.fwd2_hit  = hit[1];
   assign sb.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances share one decode stimulus stream
// (u0: DEPTH=3 forwarding, u1: DEPTH=3 stall-only, u2: DEPTH=16 stall-only for the counter).
// Expected values are queued as stimulus is driven and compared at the following falling edge.
module tb_hazard_scoreboard;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam logic [DW-1:0] RF1 = 32'hA1A1_0001;
   localparam logic [DW-1:0] RF2 = 32'hB2B2_0002;

   typedef enum int {F_STALL, F_OP1, F_OP2, F_HIT1, F_HIT2, F_CNT} fld_t;
   typedef struct {
      int          inst;
      fld_t        f;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          en, issue_valid, issue_we, issue_is_load, src1_used, src2_used, flush;
   logic [AW-1:0] issue_rd, src1_addr, src2_addr;
   logic [DW-1:0] rf1, rf2;
   logic [3*DW-1:0] sd;

   hazard_scoreboard_if #(.DATA_W(DW), .REG_AW(AW), .DEPTH(3))  if0 ();
   hazard_scoreboard_if #(.DATA_W(DW), .REG_AW(AW), .DEPTH(3))  if1 ();
   hazard_scoreboard_if #(.DATA_W(DW), .REG_AW(AW), .DEPTH(16)) if2 ();

   assign if0.en = en; assign if0.issue_valid = issue_valid; assign if0.issue_rd = issue_rd;
   assign if0.issue_we = issue_we; assign if0.issue_is_load = issue_is_load;
   assign if0.src1_addr = src1_addr; assign if0.src2_addr = src2_addr;
   assign if0.src1_used = src1_used; assign if0.src2_used = src2_used;
   assign if0.rf_rd1_data = rf1; assign if0.rf_rd2_data = rf2;
   assign if0.stage_data = sd; assign if0.flush = flush;

   assign if1.en = en; assign if1.issue_valid = issue_valid; assign if1.issue_rd = issue_rd;
   assign if1.issue_we = issue_we; assign if1.issue_is_load = issue_is_load;
   assign if1.src1_addr = src1_addr; assign if1.src2_addr = src2_addr;
   assign if1.src1_used = src1_used; assign if1.src2_used = src2_used;
   assign if1.rf_rd1_data = rf1; assign if1.rf_rd2_data = rf2;
   assign if1.stage_data = sd; assign if1.flush = flush;

   assign if2.en = en; assign if2.issue_valid = issue_valid; assign if2.issue_rd = issue_rd;
   assign if2.issue_we = issue_we; assign if2.issue_is_load = issue_is_load;
   assign if2.src1_addr = src1_addr; assign if2.src2_addr = src2_addr;
   assign if2.src1_used = src1_used; assign if2.src2_used = src2_used;
   assign if2.rf_rd1_data = rf1; assign if2.rf_rd2_data = rf2;
   assign if2.stage_data = {{(13*DW){1'b0}}, sd}; assign if2.flush = flush;

   hazard_scoreboard #(.DATA_W(DW), .REG_AW(AW), .DEPTH(3),  .LOAD_LAT(2), .FWD_EN(1'b1))
      u0 (.clk(clk), .rst(rst), .sb(if0));
   hazard_scoreboard #(.DATA_W(DW), .REG_AW(AW), .DEPTH(3),  .LOAD_LAT(2), .FWD_EN(1'b0))
      u1 (.clk(clk), .rst(rst), .sb(if1));
   hazard_scoreboard #(.DATA_W(DW), .REG_AW(AW), .DEPTH(16), .LOAD_LAT(2), .FWD_EN(1'b0))
      u2 (.clk(clk), .rst(rst), .sb(if2));

   logic          stall_o [3];
   logic          hit1_o  [3];
   logic          hit2_o  [3];
   logic [DW-1:0] op1_o   [3];
   logic [DW-1:0] op2_o   [3];
   logic [15:0]   cnt_o   [3];

   assign stall_o[0] = if0.stall; assign hit1_o[0] = if0.fwd1_hit; assign hit2_o[0] = if0.fwd2_hit;
   assign op1_o[0] = if0.op1; assign op2_o[0] = if0.op2; assign cnt_o[0] = if0.stall_cnt;
   assign stall_o[1] = if1.stall; assign hit1_o[1] = if1.fwd1_hit; assign hit2_o[1] = if1.fwd2_hit;
   assign op1_o[1] = if1.op1; assign op2_o[1] = if1.op2; assign cnt_o[1] = if1.stall_cnt;
   assign stall_o[2] = if2.stall; assign hit1_o[2] = if2.fwd1_hit; assign hit2_o[2] = if2.fwd2_hit;
   assign op1_o[2] = if2.op1; assign op2_o[2] = if2.op2; assign cnt_o[2] = if2.stall_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] observe(input int i, input fld_t f);
      case (f)
         F_STALL: return {31'd0, stall_o[i]};
         F_OP1:   return op1_o[i];
         F_OP2:   return op2_o[i];
         F_HIT1:  return {31'd0, hit1_o[i]};
         F_HIT2:  return {31'd0, hit2_o[i]};
         default: return {16'd0, cnt_o[i]};
      endcase
   endfunction

   task automatic expect_v(input int i, input fld_t f, input logic [31:0] v, input string tag);
      exp_t e;
      e.inst = i; e.f = f; e.val = v; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.inst, e.f), e.val);
      end
   endtask

   // Compare at the falling edge, then let the rising edge advance the pipeline.
   task automatic cyc();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [AW-1:0] rd, input logic we, input logic ld,
                            input logic [AW-1:0] s1, input logic u1,
                            input logic [AW-1:0] s2, input logic u2);
      issue_valid = v; issue_rd = rd; issue_we = we; issue_is_load = ld;
      src1_addr = s1; src1_used = u1; src2_addr = s2; src2_used = u2;
   endtask

   task automatic idle();
      set_issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   int nst;
   int guard;
   int w;
   bit mid_done;

   initial begin
      en = 1'b1; flush = 1'b0; rf1 = RF1; rf2 = RF2;
      sd = {32'h1234_5678, 32'h0000_00AA, 32'h0000_00EE};
      idle();
      @(posedge clk); #1;
      do_reset();

      // Reset state: no entries, operands pass straight from the register file.
      set_issue(1'b1, 4'd9, 1'b1, 1'b0, 4'd3, 1'b1, 4'd4, 1'b1);
      expect_v(0, F_STALL, 0, "rst_stall");
      expect_v(0, F_OP1, RF1, "rst_op1");
      expect_v(0, F_OP2, RF2, "rst_op2");
      expect_v(0, F_HIT1, 0, "rst_hit1");
      expect_v(0, F_CNT, 0, "rst_cnt");
      cyc();

      // ALU dependence with forwarding: one stall cycle, then both operands from entry 1.
      do_reset();
      set_issue(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1);
      expect_v(0, F_STALL, 0, "alu_issue_stall");
      cyc();
      set_issue(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1);
      expect_v(0, F_STALL, 1, "alu_stall_c1");
      expect_v(0, F_HIT1, 0, "alu_hit1_c1");
      cyc();
      expect_v(0, F_STALL, 0, "alu_stall_c2");
      expect_v(0, F_OP1, 32'hAA, "alu_op1");
      expect_v(0, F_OP2, 32'hAA, "alu_op2");
      expect_v(0, F_HIT1, 1, "alu_hit1");
      expect_v(0, F_HIT2, 1, "alu_hit2");
      expect_v(0, F_CNT, 1, "alu_cnt");
      cyc();

      // Load dependence: LOAD_LAT stall cycles, then data from entry 2.
      do_reset();
      set_issue(1'b1, 4'd5, 1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b0);
      expect_v(0, F_STALL, 0, "ld_issue_stall");
      cyc();
      set_issue(1'b1, 4'd6, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5, 1'b0);
      expect_v(0, F_STALL, 1, "ld_stall_c1");
      cyc();
      expect_v(0, F_STALL, 1, "ld_stall_c2");
      cyc();
      expect_v(0, F_STALL, 0, "ld_stall_c3");
      expect_v(0, F_OP1, 32'h1234_5678, "ld_op1");
      expect_v(0, F_HIT1, 1, "ld_hit1");
      expect_v(0, F_OP2, RF2, "ld_unused_op2");
      expect_v(0, F_HIT2, 0, "ld_unused_hit2");
      expect_v(0, F_CNT, 2, "ld_cnt");
      cyc();

      // Two writers of r2 in entries 1 and 2: the younger one (entry 1) wins.
      do_reset();
      sd = {32'h0000_0022, 32'h0000_0011, 32'h0000_00EE};
      set_issue(1'b1, 4'd2, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);
      expect_v(0, F_STALL, 0, "yw_w1_stall");
      cyc();
      expect_v(0, F_STALL, 0, "yw_w2_stall");
      cyc();
      idle();
      cyc();
      set_issue(1'b1, 4'd7, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2, 1'b1);
      expect_v(0, F_STALL, 0, "yw_stall");
      expect_v(0, F_OP1, 32'h11, "yw_op1");
      expect_v(0, F_OP2, 32'h11, "yw_op2_same_src");
      expect_v(0, F_HIT2, 1, "yw_hit2");
      cyc();
      sd = {32'h1234_5678, 32'h0000_00AA, 32'h0000_00EE};

      // Stall-only mode: DEPTH stall cycles, then the register-file value.
      do_reset();
      set_issue(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1);
      expect_v(1, F_STALL, 0, "nf_issue_stall");
      cyc();
      set_issue(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         expect_v(1, F_STALL, 1, $sformatf("nf_stall_c%0d", i + 1));
         cyc();
      end
      expect_v(1, F_STALL, 0, "nf_stall_end");
      expect_v(1, F_OP1, RF1, "nf_op1");
      expect_v(1, F_HIT1, 0, "nf_hit1");
      expect_v(1, F_CNT, 3, "nf_cnt");
      cyc();

      // Flush beats stall, and the flushed instruction does not enter entry 0.
      do_reset();
      set_issue(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1);
      cyc();
      set_issue(1'b1, 4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd2, 1'b0);
      flush = 1'b1;
      expect_v(0, F_STALL, 0, "fl_stall");
      cyc();
      flush = 1'b0;
      set_issue(1'b1, 4'd7, 1'b1, 1'b0, 4'd6, 1'b1, 4'd2, 1'b0);
      expect_v(0, F_STALL, 0, "fl_bubble_stall");
      expect_v(0, F_OP1, RF1, "fl_bubble_op1");
      expect_v(0, F_HIT1, 0, "fl_bubble_hit1");
      expect_v(0, F_CNT, 0, "fl_cnt");
      cyc();

      // en=0 with a hazard: stall still visible, entries and counter frozen.
      do_reset();
      set_issue(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1);
      cyc();
      set_issue(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd2, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expect_v(0, F_STALL, 1, $sformatf("en0_stall_%0d", i));
         expect_v(0, F_CNT, 0, $sformatf("en0_cnt_%0d", i));
         cyc();
      end
      en = 1'b1;
      expect_v(0, F_STALL, 1, "en1_stall");
      cyc();
      expect_v(0, F_STALL, 0, "en1_fwd_stall");
      expect_v(0, F_OP1, 32'hAA, "en1_op1");
      expect_v(0, F_CNT, 1, "en1_cnt");
      cyc();

      // Self-dependent chain on the 16-deep stall-only unit drives the counter into saturation.
      do_reset();
      set_issue(1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b0);
      nst = 0; guard = 0; mid_done = 1'b0;
      while (nst < 70000 && guard < 80000) begin
         @(negedge clk);
         if (nst == 65534 && !mid_done) begin
            mid_done = 1'b1;
            expect_v(2, F_CNT, 32'hFFFE, "cnt_pre_sat");
            drain();
         end
         if (stall_o[2]) nst++;
         guard++;
         @(posedge clk); #1;
      end
      if (nst < 70000) check("cnt_stall_budget", nst, 70000);
      expect_v(2, F_CNT, 32'hFFFF, "cnt_saturated");
      @(negedge clk);
      drain();

      // Reset in the middle of a stall clears everything without waiting for a clock.
      w = 0;
      while (!stall_o[2] && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!stall_o[2]) check("rst_mid_wait", {31'd0, stall_o[2]}, 1);
      #2;
      rst = 1'b1;
      #1;
      expect_v(2, F_STALL, 0, "rst_mid_stall");
      expect_v(2, F_CNT, 0, "rst_mid_cnt");
      drain();
      #1;
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and operand-forwarding unit for the pipelined core. It sits between decode (register read) and execute. It tracks every in-flight destination register in a shift-register scoreboard, one entry per downstream stage. It replaces the fixed count-based stall logic with per-operand forwarding or stalling, depending on pipeline depth, load latency and mode.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 4, register address width (2^REG_AW registers)
- DEPTH, 3, scoreboard entries (stages after decode); entry 0 = EX, entry DEPTH-1 = WB
- LOAD_LAT, 2, first entry index at which a load result is valid; must satisfy 1 ≤ LOAD_LAT ≤ DEPTH-1
- FWD_EN, 1, 1 = forward when possible; 0 = stall-only mode

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global advance enable; 0 freezes all state
- issue_valid  in  1  decode holds a valid instruction
- issue_rd  in  REG_AW  destination register of decode instruction
- issue_we  in  1  decode instruction writes issue_rd
- issue_is_load  in  1  decode instruction is a load
- src1_addr, src2_addr  in  REG_AW  source registers
- src1_used, src2_used  in  1  source is actually read
- rf_rd1_data, rf_rd2_data  in  DATA_W  register-file read data
- stage_data  in  DEPTH*DATA_W  result bus of entry k at bits [k*DATA_W +: DATA_W]
- flush  in  1  kill the decode instruction (branch taken in EX)
- stall  out  1  hold fetch/decode, insert bubble
- op1, op2  out  DATA_W  resolved operands
- fwd1_hit, fwd2_hit  out  1  operand taken from stage_data
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Each entry holds: valid, rd, we, is_load.
- Ready(k) = valid && we && k ≥ 1 && (!is_load || k ≥ LOAD_LAT). Entry 0 is never ready, because no EX-to-decode combinational path exists.
- Per source s with src_used: search entries 0..DEPTH-1, youngest (lowest k) first, for valid && we && rd == src_addr.
  - No match: op = rf data, hit = 0, no hazard.
  - Match at k, FWD_EN=1, Ready(k): op = stage_data[k], hit = 1, no hazard.
  - Match at k, otherwise: hazard. Only the youngest match is considered, even when an older entry is ready.
  - Unused source: op = rf data, hit = 0, never a hazard.
- stall = issue_valid && (hazard1 || hazard2) && !flush.
- Advance, on a rising edge with en=1:
  - Entry k+1 ← entry k, for k = 0..DEPTH-2.
  - Entry DEPTH-1 is discarded; the register file writes it that cycle.
  - Entry 0 ← decode instruction if issue_valid && !stall && !flush; otherwise a bubble (valid=0).
- en=0: all entries and stall_cnt hold. stall and op outputs still reflect the current state.
- stall_cnt increments on each edge with en=1 && stall=1, and saturates at 0xFFFF.

## Timing
- Reset (async assert): all entries invalid; stall_cnt=0.
- After reset, stall=0, and op1/op2 equal rf data, until the first issue.
- stall, op1, op2, fwd*_hit are combinational, from current state plus decode inputs.
- Scoreboard update latency is 1 cycle.
- Stall cycles for a dependence on the immediately preceding instruction:
  - ALU, FWD_EN=1: 1 cycle.
  - Load, FWD_EN=1: LOAD_LAT cycles.
  - Any, FWD_EN=0: DEPTH cycles.
- flush together with stall: flush wins. stall=0, and a bubble enters entry 0.
- Reset mid-stall: stall deasserts asynchronously with the entries cleared.
- Same rd in several entries: youngest wins.
- src1_addr == src2_addr: both resolve identically.

## Test plan
- DEPTH=3, FWD_EN=1. ADD r3 issued, then SUB r4,r3,r3 the next cycle:
  - stall=1 for exactly 1 cycle.
  - Next cycle, op1=op2=stage_data[1]=0x0000_00AA and fwd1_hit=fwd2_hit=1.
  - stall_cnt=1.
- LD r5 (LOAD_LAT=2), then a user of r5:
  - stall=1 for 2 cycles.
  - Then op1=stage_data[2]=0x1234_5678.
- Writers of r2 sit in entries 1 (value 0x11) and 2 (value 0x22); the next instruction uses r2:
  - op1=0x11, no stall.
- FWD_EN=0. ADD r3, then a user of r3:
  - stall=1 for 3 cycles.
  - Then op1=rf_rd1_data, fwd1_hit=0.
- Hazard present with flush=1:
  - stall=0, and entry 0 becomes invalid next cycle.
- Counter, en and reset:
  - Force 70000 stall cycles: stall_cnt=0xFFFF.
  - en=0 for 5 cycles with a hazard present: entries and stall_cnt frozen.
  - Assert rst mid-stall: stall=0 immediately and stall_cnt=0.
